// File: rtl/uc_multiciclo_if.sv
// rtl/uc_multiciclo_if.sv - instruction fields in, datapath controls out, for the multicycle control unit
interface uc_multiciclo_if #(
  parameter int ALUCTRL_W = 3,
  parameter int INSTRET_W = 32
);
  logic [6:0]           op;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           imm_src;
  logic                 reg_write;
  logic [ALUCTRL_W-1:0] alu_control;
  logic                 trap;
  logic [INSTRET_W-1:0] instret;

  // control unit side
  modport master (
    input  op, f3, f7, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, trap, instret
  );

  // datapath side
  modport slave (
    output op, f3, f7, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, trap, instret
  );
endinterface

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle RV32I-subset control FSM; define UC_BNE_EN to add bne
module uc_multiciclo #(
  parameter int ALUCTRL_W = 3,
  parameter int INSTRET_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  uc_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 trap_q, trap_d;
  logic                 adr_src_q, adr_src_d;
  logic                 reg_write_q, reg_write_d;
  logic [1:0]           result_src_q, result_src_d;
  logic [1:0]           alu_src_a_q, alu_src_a_d;
  logic [1:0]           alu_src_b_q, alu_src_b_d;
  aluop_t               aluop_q, aluop_d;
  logic                 branch_taken;
  logic                 pc_write_c, ir_write_c, mem_write_c;
  logic [2:0]           funct_code, alu_code;
  logic [1:0]           imm_src_c;

`ifdef UC_BNE_EN
  assign branch_taken = (bus.f3 == 3'b001) ? ~bus.zero : bus.zero;
`else
  assign branch_taken = bus.zero;
`endif

  // Next state, retirement counting and the sticky trap flag
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
`ifdef UC_BNE_EN
          7'b1100011: state_d = (bus.f3 == 3'b000 || bus.f3 == 3'b001) ? S_BEQ : S_ILLEGAL;
`else
          7'b1100011:             state_d = S_BEQ;
`endif
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d   = S_FETCH;
        instret_d = instret_q + INSTRET_W'(1);
      end
      S_MEMWRITE: begin
        if (bus.mem_ready) begin
          state_d   = S_FETCH;
          instret_d = instret_q + INSTRET_W'(1);
        end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB, S_BEQ: begin
        state_d   = S_FETCH;
        instret_d = instret_q + INSTRET_W'(1);
      end
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
    trap_d = trap_q | (state_d == S_ILLEGAL);
  end

  // Moore selects for the state being entered, so they are registered alongside it
  always_comb begin
    adr_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    aluop_d      = ALUOP_ADD;
    case (state_d)
      S_FETCH:    begin alu_src_b_d = 2'b10; result_src_d = 2'b10; end
      S_DECODE:   begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b01; end
      S_MEMADR:   begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; end
      S_MEMREAD:  adr_src_d = 1'b1;
      S_MEMWB:    begin result_src_d = 2'b01; reg_write_d = 1'b1; end
      S_MEMWRITE: adr_src_d = 1'b1;
      S_EXECR:    begin alu_src_a_d = 2'b10; aluop_d = ALUOP_FUNCT; end
      S_EXECI:    begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; aluop_d = ALUOP_FUNCT; end
      S_ALUWB:    reg_write_d = 1'b1;
      S_JAL:      begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b10; end
      S_BEQ:      begin alu_src_a_d = 2'b10; aluop_d = ALUOP_SUB; end
      default:    ;
    endcase
  end

  // State and registered outputs; reset values are the FETCH outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      instret_q    <= '0;
      trap_q       <= 1'b0;
      adr_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b10;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b10;
      aluop_q      <= ALUOP_ADD;
    end else begin
      state_q      <= state_d;
      instret_q    <= instret_d;
      trap_q       <= trap_d;
      adr_src_q    <= adr_src_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      aluop_q      <= aluop_d;
    end
  end

  // Enables that depend on mem_ready/zero this cycle; held low while reset is asserted
  always_comb begin
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    case (state_q)
      S_FETCH:    begin pc_write_c = bus.mem_ready; ir_write_c = bus.mem_ready; end
      S_MEMWRITE: mem_write_c = 1'b1;
      S_JAL:      pc_write_c = 1'b1;
      S_BEQ:      pc_write_c = branch_taken;
      default:    ;
    endcase
    pc_write_c  = pc_write_c  & rst_n;
    ir_write_c  = ir_write_c  & rst_n;
    mem_write_c = mem_write_c & rst_n;
  end

  // ALU operation: fixed add/sub, or decoded from funct3/funct7
  always_comb begin
    case (bus.f3)
      3'b000:  funct_code = (bus.op[5] & bus.f7[5]) ? 3'b001 : 3'b000;
      3'b010:  funct_code = 3'b101;
      3'b110:  funct_code = 3'b011;
      3'b111:  funct_code = 3'b010;
      default: funct_code = 3'b000;
    endcase
    case (aluop_q)
      ALUOP_SUB:   alu_code = 3'b001;
      ALUOP_FUNCT: alu_code = funct_code;
      default:     alu_code = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (bus.op)
      7'b0100011: imm_src_c = 2'b01;
      7'b1100011: imm_src_c = 2'b10;
      7'b1101111: imm_src_c = 2'b11;
      default:    imm_src_c = 2'b00;
    endcase
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ir_write    = ir_write_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.adr_src     = adr_src_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.result_src  = result_src_q;
  assign bus.alu_src_a   = alu_src_a_q;
  assign bus.alu_src_b   = alu_src_b_q;
  assign bus.imm_src     = imm_src_c;
  assign bus.alu_control = ALUCTRL_W'(alu_code);
  assign bus.trap        = trap_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - self-checking bench for uc_multiciclo with a per-instruction reference model
module tb_uc_multiciclo;

  localparam int AW = 4;
  localparam int IW = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uc_multiciclo_if #(.ALUCTRL_W(AW), .INSTRET_W(IW)) bus ();
  uc_multiciclo #(.ALUCTRL_W(AW), .INSTRET_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int exp_instret = 0;

  logic          obs_ir  [0:63];
  logic          obs_pc  [0:63];
  logic          obs_rw  [0:63];
  logic          obs_mw  [0:63];
  logic          obs_adr [0:63];
  logic [1:0]    obs_rs  [0:63];
  logic [1:0]    obs_imm [0:63];
  logic [AW-1:0] obs_alu [0:63];

  function automatic int exp_cycles(input logic [6:0] op, input int fs, input int ms);
    case (op)
      OP_LW:  return fs + ms + 5;
      OP_SW:  return fs + ms + 4;
      OP_BR:  return fs + 3;
      default: return fs + 4;
    endcase
  endfunction

  function automatic int exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (op == OP_BR) return 1;
    if (op != OP_R && op != OP_I) return 0;
    case (f3)
      3'd0: return (op[5] && f7[5]) ? 1 : 0;
      3'd2: return 5;
      3'd6: return 3;
      3'd7: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_imm(input logic [6:0] op);
    case (op)
      OP_SW:  return 1;
      OP_BR:  return 2;
      OP_JAL: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_taken(input logic [2:0] f3, input logic z);
`ifdef UC_BNE_EN
    return (f3 == 3'b001) ? !z : z;
`else
    return z;
`endif
  endfunction

  // Drives one instruction for ncyc cycles starting right after a FETCH-entry edge.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int fs, input int ms, input int ncyc);
    int mstart;
    mstart = (op == OP_LW || op == OP_SW) ? fs + 3 : -1;
    bus.op = op; bus.f3 = f3; bus.f7 = f7; bus.zero = z;
    for (int c = 0; c < ncyc; c++) begin
      if (c <= fs) bus.mem_ready = (c == fs);
      else if (mstart >= 0 && c >= mstart) bus.mem_ready = (c == mstart + ms);
      else bus.mem_ready = 1'($urandom);
      @(negedge clk);
      obs_ir[c] = bus.ir_write;   obs_pc[c] = bus.pc_write;
      obs_rw[c] = bus.reg_write;  obs_mw[c] = bus.mem_write;
      obs_adr[c] = bus.adr_src;   obs_rs[c] = bus.result_src;
      obs_imm[c] = bus.imm_src;   obs_alu[c] = bus.alu_control;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.op = OP_LW; bus.f3 = 3'd0; bus.f7 = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_enables got %b want 0000", {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write});
    end
    checks++;
    if (bus.trap !== 1'b0 || bus.instret !== '0) begin
      errors++; $display("FAIL reset_trap_instret got trap=%b instret=%0d want 0/0", bus.trap, bus.instret);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 3'd2, 7'd0, 1'b0, 0, 0, 5);
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (obs_ir[0] !== 1'b1 || obs_pc[0] !== 1'b1) begin
      errors++; $display("FAIL lw_fetch got ir=%b pc=%b want 1/1", obs_ir[0], obs_pc[0]);
    end
    checks++;
    if (obs_adr[3] !== 1'b1) begin
      errors++; $display("FAIL lw_memread_adr got %b want 1", obs_adr[3]);
    end
    checks++;
    if (obs_rw[4] !== 1'b1 || obs_rs[4] !== 2'b01) begin
      errors++; $display("FAIL lw_wb got rw=%b rs=%b want 1/01", obs_rw[4], obs_rs[4]);
    end
    checks++;
    if (int'(bus.instret) !== exp_instret) begin
      errors++; $display("FAIL lw_instret got %0d want %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_fetch_stall();
    run_instr(OP_LW, 3'd2, 7'd0, 1'b0, 3, 0, 8);
    exp_instret = (exp_instret + 1) % (1 << IW);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_ir[c] !== 1'b0 || obs_pc[c] !== 1'b0) begin
        errors++; $display("FAIL stall_fetch c%0d got ir=%b pc=%b want 0/0", c, obs_ir[c], obs_pc[c]);
      end
    end
    checks++;
    if (obs_ir[3] !== 1'b1) begin
      errors++; $display("FAIL stall_release got ir=%b want 1", obs_ir[3]);
    end
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 3'b000, 7'b0100000, 1'b0, 0, 0, 4);
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (obs_alu[2] !== AW'(1)) begin
      errors++; $display("FAIL r_sub_alu got %0d want 1", obs_alu[2]);
    end
    checks++;
    if (obs_rw[3] !== 1'b1 || obs_rs[3] !== 2'b00) begin
      errors++; $display("FAIL r_sub_wb got rw=%b rs=%b want 1/00", obs_rw[3], obs_rs[3]);
    end
    run_instr(OP_R, 3'b110, 7'b0000000, 1'b0, 0, 0, 4);
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (obs_alu[2] !== AW'(3)) begin
      errors++; $display("FAIL r_or_alu got %0d want 3", obs_alu[2]);
    end
  endtask

  task automatic test_beq();
    run_instr(OP_BR, 3'b000, 7'd0, 1'b1, 0, 0, 3);
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (obs_pc[2] !== 1'b1) begin
      errors++; $display("FAIL beq_taken got pc=%b want 1", obs_pc[2]);
    end
    run_instr(OP_BR, 3'b000, 7'd0, 1'b0, 0, 0, 3);
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (obs_ir[0] !== 1'b1) begin
      errors++; $display("FAIL beq_refetch got ir=%b want 1", obs_ir[0]);
    end
    checks++;
    if (obs_pc[2] !== 1'b0) begin
      errors++; $display("FAIL beq_not_taken got pc=%b want 0", obs_pc[2]);
    end
    checks++;
    if (int'(bus.instret) !== exp_instret) begin
      errors++; $display("FAIL beq_instret got %0d want %0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [0:5];
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I; ops[4] = OP_JAL; ops[5] = OP_BR;
    for (int k = 0; k < 40; k++) begin
      logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic z;
      int fs, ms, n, ir_first, pc_n, rw_n, mw_n, adr_n, imm_bad, wr, want_pc;
      op = ops[$urandom_range(0, 5)];
      f3 = 3'($urandom); f7 = 7'($urandom); z = 1'($urandom);
`ifdef UC_BNE_EN
      if (op == OP_BR) f3 = 3'($urandom_range(0, 1));
`endif
      fs = $urandom_range(0, 3); ms = $urandom_range(0, 3);
      n = exp_cycles(op, fs, ms);
      run_instr(op, f3, f7, z, fs, ms, n);
      exp_instret = (exp_instret + 1) % (1 << IW);
      ir_first = -1; pc_n = 0; rw_n = 0; mw_n = 0; adr_n = 0; imm_bad = 0;
      for (int c = n - 1; c >= 0; c--) begin
        if (obs_ir[c] === 1'b1) ir_first = c;
        pc_n += int'(obs_pc[c] === 1'b1);
        rw_n += int'(obs_rw[c] === 1'b1);
        mw_n += int'(obs_mw[c] === 1'b1);
        adr_n += int'(obs_adr[c] === 1'b1);
        imm_bad += int'(int'(obs_imm[c]) !== exp_imm(op));
      end
      wr = (op == OP_LW || op == OP_R || op == OP_I || op == OP_JAL) ? 1 : 0;
      want_pc = 1 + int'(op == OP_JAL) + int'(op == OP_BR && exp_taken(f3, z));
      checks++;
      if (ir_first !== fs) begin
        errors++; $display("FAIL rnd_ir #%0d op=%b got first=%0d want %0d", k, op, ir_first, fs);
      end
      checks++;
      if (pc_n !== want_pc) begin
        errors++; $display("FAIL rnd_pc #%0d op=%b f3=%0d z=%b got %0d want %0d", k, op, f3, z, pc_n, want_pc);
      end
      checks++;
      if (rw_n !== wr || (wr == 1 && obs_rw[n-1] !== 1'b1)) begin
        errors++; $display("FAIL rnd_rw #%0d op=%b got %0d want %0d", k, op, rw_n, wr);
      end
      checks++;
      if (mw_n !== ((op == OP_SW) ? ms + 1 : 0)) begin
        errors++; $display("FAIL rnd_mw #%0d op=%b got %0d want %0d", k, op, mw_n, (op == OP_SW) ? ms + 1 : 0);
      end
      checks++;
      if (adr_n !== ((op == OP_SW || op == OP_LW) ? ms + 1 : 0)) begin
        errors++; $display("FAIL rnd_adr #%0d op=%b got %0d want %0d", k, op, adr_n, (op == OP_SW || op == OP_LW) ? ms + 1 : 0);
      end
      checks++;
      if (int'(obs_rs[n-1]) !== ((op == OP_LW) ? 1 : 0)) begin
        errors++; $display("FAIL rnd_rs #%0d op=%b got %0d", k, op, obs_rs[n-1]);
      end
      checks++;
      if (obs_alu[fs+2] !== AW'(exp_alu(op, f3, f7))) begin
        errors++; $display("FAIL rnd_alu #%0d op=%b f3=%0d f7=%b got %0d want %0d", k, op, f3, f7, obs_alu[fs+2], exp_alu(op, f3, f7));
      end
      checks++;
      if (imm_bad !== 0) begin
        errors++; $display("FAIL rnd_imm #%0d op=%b got %0d bad cycles want 0", k, op, imm_bad);
      end
      checks++;
      if (int'(bus.instret) !== exp_instret) begin
        errors++; $display("FAIL rnd_instret #%0d got %0d want %0d", k, bus.instret, exp_instret);
      end
    end
  endtask

  task automatic test_illegal();
    run_instr(7'b0000001, 3'd0, 7'd0, 1'b0, 0, 0, 2);
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.trap !== 1'b1 || {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write} !== 4'b0000) begin
        errors++; $display("FAIL illegal_hold c%0d got trap=%b en=%b want 1/0000", c, bus.trap,
                           {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write});
      end
      @(posedge clk); #1;
    end
    checks++;
    if (int'(bus.instret) !== exp_instret) begin
      errors++; $display("FAIL illegal_instret got %0d want %0d", bus.instret, exp_instret);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.trap !== 1'b0) begin
      errors++; $display("FAIL illegal_reset_trap got %b want 0", bus.trap);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  task automatic test_reset_mid_write();
    run_instr(OP_SW, 3'd2, 7'd0, 1'b0, 0, 9, 3);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_write !== 1'b1) begin
      errors++; $display("FAIL sw_stall_write got %b want 1", bus.mem_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.trap !== 1'b0 || bus.instret !== '0) begin
      errors++; $display("FAIL mid_reset got mw=%b trap=%b instret=%0d want 0/0/0", bus.mem_write, bus.trap, bus.instret);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 0;
    run_instr(OP_I, 3'b111, 7'd0, 1'b0, 0, 0, 4);
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (obs_ir[0] !== 1'b1 || obs_alu[2] !== AW'(2)) begin
      errors++; $display("FAIL after_reset got ir=%b alu=%0d want 1/2", obs_ir[0], obs_alu[2]);
    end
    checks++;
    if (int'(bus.instret) !== exp_instret) begin
      errors++; $display("FAIL after_reset_instret got %0d want %0d", bus.instret, exp_instret);
    end
  endtask

`ifdef UC_BNE_EN
  task automatic test_bne();
    run_instr(OP_BR, 3'b001, 7'd0, 1'b0, 0, 0, 3);
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (obs_pc[2] !== 1'b1) begin
      errors++; $display("FAIL bne_taken got pc=%b want 1", obs_pc[2]);
    end
    run_instr(OP_BR, 3'b100, 7'd0, 1'b1, 0, 0, 2);
    @(negedge clk);
    checks++;
    if (bus.trap !== 1'b1) begin
      errors++; $display("FAIL blt_illegal got trap=%b want 1", bus.trap);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_fetch_stall();
    test_rtype();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid_write();
`ifdef UC_BNE_EN
    test_bne();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
